// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared integer ALU, with a one-entry tagged result register.
// Build option: define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority (no round-robin pointer).

module alu_arbiter_alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic [WIDTH-1:0] rd
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    logic [4:0] shamt;
    assign shamt = rs2[4:0];

    // NOTE: rd is defaulted before the case so no op value can leave it unassigned and infer a latch.
    always_comb begin
        rd = '0;
        case (op)
            ALU_ADD:  rd = rs1 + rs2;
            ALU_SUB:  rd = rs1 - rs2;
            ALU_AND:  rd = rs1 & rs2;
            ALU_OR:   rd = rs1 | rs2;
            ALU_XOR:  rd = rs1 ^ rs2;
            ALU_SLT:  rd = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            ALU_SLTU: rd = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            ALU_SLL:  rd = rs1 << shamt;
            ALU_SRL:  rd = rs1 >> shamt;
            ALU_SRA:  rd = $signed(rs1) >>> shamt;
            default:  rd = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_rd,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    out_state_t       state_q, state_d;
    logic             out_owner;
    logic             drain, can_accept, pick1, grant0, grant1, grant;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_rs1, alu_rs2, alu_rd;

    assign drain      = (state_q == FULL) & (out_owner ? resp1_ready : resp0_ready);
    assign can_accept = (state_q == EMPTY) | drain;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick1 = ~req0_valid;
`else
    logic rr_ptr;
    // Port 1 wins when it is the only requester or when it holds the round-robin turn.
    assign pick1 = req1_valid & (~req0_valid | rr_ptr);
`endif

    assign grant0 = can_accept & req0_valid & ~pick1;
    assign grant1 = can_accept & req1_valid & pick1;
    assign grant  = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_op  = pick1 ? req1_op  : req0_op;
    assign alu_rs1 = pick1 ? req1_rs1 : req0_rs1;
    assign alu_rs2 = pick1 ? req1_rs2 : req0_rs2;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (alu_op),
        .rs1 (alu_rs1),
        .rs2 (alu_rs2),
        .rd  (alu_rd)
    );

    // A grant in the same cycle as a drain overwrites the register and keeps it full.
    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_owner <= 1'b0;
            resp_rd   <= '0;
            resp_tag  <= '0;
        end else if (grant) begin
            out_owner <= pick1;
            resp_rd   <= alu_rd;
            resp_tag  <= pick1 ? req1_tag : req0_tag;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= ~pick1;
        end
    end
`endif

    assign busy        = (state_q == FULL);
    assign resp0_valid = (state_q == FULL) & ~out_owner;
    assign resp1_valid = (state_q == FULL) &  out_owner;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus constrained-random traffic against a
// transaction-level scoreboard (expected-result queue, last-winner fairness rule, arithmetic ALU model).

module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic [3:0]       req0_op = '0, req1_op = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             resp0_valid, resp1_valid;
    logic             resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [WIDTH-1:0] resp_rd;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    alu_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_rs1    (req0_rs1),
        .req0_rs2    (req0_rs2),
        .req0_op     (req0_op),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_rs1    (req1_rs1),
        .req1_rs2    (req1_rs2),
        .req1_op     (req1_op),
        .req1_tag    (req1_tag),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_rd     (resp_rd),
        .resp_tag    (resp_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               port;
        logic [WIDTH-1:0] rd;
        logic [TAG_W-1:0] tag;
    } result_t;

    result_t exp_q[$];
    int      last_winner = 1;
    bit      last_g0, last_g1;
    logic    obs_r0, obs_r1;
    int      compared = 0;
    int      mismatched = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return int'(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // One clock of traffic: inputs are already driven; checks handshakes, advances, checks the result register.
    task automatic tick();
        bit drain_e, room, p0_wins, g0, g1;
        #2;
        drain_e = (exp_q.size() != 0) && (exp_q[0].port ? resp1_ready : resp0_ready);
        room    = (exp_q.size() == 0) || drain_e;
`ifdef ALU_ARB_FIXED_PRIO_EN
        p0_wins = 1'b1;
`else
        p0_wins = (last_winner == 1);
`endif
        g0 = room && req0_valid && (!req1_valid || p0_wins);
        g1 = room && req1_valid && (!req0_valid || !p0_wins);
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("resp0_valid", resp0_valid, (exp_q.size() != 0) && !exp_q[0].port);
        check("resp1_valid", resp1_valid, (exp_q.size() != 0) && exp_q[0].port);
        @(posedge clk);
        if (drain_e) void'(exp_q.pop_front());
        if (g0) begin
            exp_q.push_back('{1'b0, alu_ref(req0_op, req0_rs1, req0_rs2), req0_tag});
            last_winner = 0;
        end else if (g1) begin
            exp_q.push_back('{1'b1, alu_ref(req1_op, req1_rs1, req1_rs2), req1_tag});
            last_winner = 1;
        end
        last_g0 = g0;
        last_g1 = g1;
        #1;
        check("busy", busy, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("resp_rd", resp_rd, exp_q[0].rd);
            check("resp_tag", resp_tag, exp_q[0].tag);
        end
    endtask

    initial begin
        // Reset and idle.
        #3;
        check("reset_busy", busy, 1'b0);
        check("reset_rd", resp_rd, 32'h0);
        check("reset_tag", resp_tag, 4'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        tick();
        check("idle_rd", resp_rd, 32'h0);

        // Single ADD on port 0.
        req0_valid = 1; req0_op = OP_ADD; req0_rs1 = 5; req0_rs2 = 7; req0_tag = 3; resp0_ready = 1; resp1_ready = 1;
        tick();
        check("add_ready", obs_r0, 1'b1);
        check("add_rd", resp_rd, 32'd12);
        check("add_tag", resp_tag, 4'd3);
        check("add_resp0_valid", resp0_valid, 1'b1);
        check("add_resp1_valid", resp1_valid, 1'b0);

        // Port 1 alone: SLL with an over-wide shift amount.
        req0_valid = 0;
        req1_valid = 1; req1_op = OP_SLL; req1_rs1 = 1; req1_rs2 = 32'h21; req1_tag = 7;
        tick();
        check("sll_masked_rd", resp_rd, 32'd2);
        check("sll_resp1_valid", resp1_valid, 1'b1);

        // Contention every cycle with both consumers ready.
        req0_valid = 1; req0_op = OP_SLTU; req0_rs1 = 1; req0_rs2 = 32'hFFFF_FFFF;
        req1_valid = 1; req1_op = OP_SRA;  req1_rs1 = 32'h8000_0000; req1_rs2 = 4;
        for (int i = 0; i < 4; i++) begin
            req0_tag = 4'(i);
            req1_tag = 4'(8 + i);
            tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("fixed_grant0", obs_r0, 1'b1);
            check("fixed_grant1", obs_r1, 1'b0);
            check("fixed_rd", resp_rd, 32'd1);
`else
            check("alt_grant0", obs_r0, (i % 2) == 0);
            check("alt_grant1", obs_r1, (i % 2) == 1);
            check("alt_rd", resp_rd, ((i % 2) == 0) ? 32'd1 : 32'hF800_0000);
`endif
        end

        // Backpressure on port 0, then drain and grant in one cycle.
        req1_valid = 0;
        req0_op = OP_ADD; req0_rs1 = 100; req0_rs2 = 23; req0_tag = 5; resp0_ready = 0;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = OP_XOR; req1_rs1 = 32'hF0F0; req1_rs2 = 32'h0FF0; req1_tag = 9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready1", obs_r1, 1'b0);
            check("stall_rd", resp_rd, 32'd123);
            check("stall_tag", resp_tag, 4'd5);
        end
        resp0_ready = 1;
        tick();
        check("drain_grant1", obs_r1, 1'b1);
        check("drain_resp1_valid", resp1_valid, 1'b1);
        check("drain_rd", resp_rd, 32'hFF00);
        req1_valid = 0;

        // Edge ops on port 0.
        req0_valid = 1; req0_op = OP_SLT; req0_rs1 = 32'hFFFF_FFFF; req0_rs2 = 0; req0_tag = 1;
        tick();
        check("slt_rd", resp_rd, 32'd1);
        req0_op = 4'hF; req0_rs1 = 32'h1234; req0_rs2 = 32'h5678; req0_tag = 2;
        tick();
        check("undef_rd", resp_rd, 32'd0);
        check("undef_resp0_valid", resp0_valid, 1'b1);
        req0_valid = 0;
        tick();

        // Random traffic; a request is held unchanged until the model says it was accepted.
        for (int n = 0; n < 400; n++) begin
            if (!(req0_valid && !last_g0)) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op = 4'($urandom_range(0, 15));
                req0_rs1 = rand_operand();
                req0_rs2 = rand_operand();
                req0_tag = 4'($urandom);
            end
            if (!(req1_valid && !last_g1)) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op = 4'($urandom_range(0, 15));
                req1_rs1 = rand_operand();
                req1_rs2 = rand_operand();
                req1_tag = 4'($urandom);
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Flush, then reset while a port 0 result is stalled.
        req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
        tick();
        tick();
        req0_valid = 1; req0_op = OP_ADD; req0_rs1 = 1; req0_rs2 = 1; req0_tag = 6; resp0_ready = 0;
        tick();
        req0_valid = 0;
        rst_n = 1'b0;
        #1;
        check("rst_resp0_valid", resp0_valid, 1'b0);
        check("rst_resp1_valid", resp1_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        exp_q.delete();
        last_winner = 1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp0_ready = 1;
        tick();
        check("post_rst_no_stale", resp0_valid, 1'b0);
        req0_valid = 1; req0_op = OP_ADD; req0_rs1 = 2; req0_rs2 = 3; req0_tag = 4;
        req1_valid = 1; req1_op = OP_ADD; req1_rs1 = 9; req1_rs2 = 9; req1_tag = 8;
        tick();
        check("post_rst_grant0", obs_r0, 1'b1);
        check("post_rst_grant1", obs_r1, 1'b0);
        req0_valid = 0;
        tick();
        req1_valid = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
